register_mp: RTL and testbench

Parametrised multi-port integer register file for the core pipeline. It sits between decode/issue and writeback. It provides N registered read ports, M write ports, same-cycle write-to-read forwarding, and a per-register busy scoreboard so issue logic can detect pending producers. It supersedes the fixed 2-read/1-write file for dual-issue and extension configurations.

---
 rtl/register_mp.sv | 109 ++++++++++
 tb/tb_register_mp.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/register_mp.sv
// register_mp: multi-port integer register file with forwarding and a busy scoreboard.
// Ports: CLK/RST/STALL; N captured read ports (REG_IR_*); M write ports (REG_IW_*); reserve (REG_RSV_*).
module register_mp #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1,
  parameter int ZERO_REG    = 1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             STALL,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] REG_IR_I_A,
  output logic [READ_PORTS*ADDR_WIDTH-1:0] REG_IR_O_A,
  output logic [READ_PORTS*DATA_WIDTH-1:0] REG_IR_O_AV,
  output logic [READ_PORTS-1:0]            REG_IR_O_BUSY,
  input  logic [WRITE_PORTS-1:0]           REG_IW_I_EN,
  input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] REG_IW_I_A,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] REG_IW_I_AV,
  input  logic                             REG_RSV_I_EN,
  input  logic [ADDR_WIDTH-1:0]            REG_RSV_I_A
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0]       mem;
  logic [DEPTH-1:0]                       busy;
  logic [DEPTH-1:0]                       busy_next;
  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  rd_addr;
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  rd_data;
  logic [READ_PORTS-1:0]                  rd_busy;
  logic [READ_PORTS-1:0]                  fwd_hit;
  logic [WRITE_PORTS-1:0]                 wr_en;
  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] wr_addr;
  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] wr_data;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr_en   = REG_IW_I_EN;
  assign wr_addr = REG_IW_I_A;
  assign wr_data = REG_IW_I_AV;

  // Read address capture; STALL freezes the issue-side view.
  always_ff @(posedge CLK) begin
    if (RST)
      rd_addr <= '0;
    else if (!STALL)
      rd_addr <= REG_IR_I_A;
  end

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem <= '0;
    end else begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (wr_en[w] && !is_zero(wr_addr[w]))
          mem[wr_addr[w]] <= wr_data[w];
      end
    end
  end

  // Reserve is applied after the clears: a new producer outranks
  // the write retiring in the same cycle.
  always_comb begin
    busy_next = busy;
    for (int w = 0; w < WRITE_PORTS; w++) begin
      if (wr_en[w])
        busy_next[wr_addr[w]] = 1'b0;
    end
    if (REG_RSV_I_EN && !STALL && !is_zero(REG_RSV_I_A))
      busy_next[REG_RSV_I_A] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      busy <= '0;
    else
      busy <= busy_next;
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    fwd_hit = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      rd_data[k] = mem[rd_addr[k]];
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (wr_en[w] && wr_addr[w] == rd_addr[k]) begin
          rd_data[k] = wr_data[w];
          fwd_hit[k] = 1'b1;
        end
      end
      // A write landing this cycle retires the pending producer.
      rd_busy[k] = busy[rd_addr[k]] && !fwd_hit[k];
      if (is_zero(rd_addr[k])) begin
        rd_data[k] = '0;
        rd_busy[k] = 1'b0;
      end
    end
  end

  assign REG_IR_O_A    = rd_addr;
  assign REG_IR_O_AV   = rd_data;
  assign REG_IR_O_BUSY = rd_busy;

endmodule

// File: tb/tb_register_mp.sv
// tb_register_mp: vector table plus hand sequences for register_mp,
// two read ports and two write ports, register 0 hardwired.
module tb_register_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RP = 2;
  localparam int WP = 2;

  typedef struct {
    logic          rst;
    logic          stall;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [1:0]    wen;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          rsv;
    logic [AW-1:0] rsva;
    logic          chk;
    logic [AW-1:0] oa0;
    logic [AW-1:0] oa1;
    logic [DW-1:0] av0;
    logic [DW-1:0] av1;
    logic [1:0]    bz;
  } vec_t;

  typedef struct {
    logic [AW-1:0] oa0;
    logic [AW-1:0] oa1;
    logic [DW-1:0] av0;
    logic [DW-1:0] av1;
    logic [1:0]    bz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic [RP*AW-1:0] ir_a;
  logic [RP*AW-1:0] or_a;
  logic [RP*DW-1:0] or_av;
  logic [RP-1:0]    or_busy;
  logic [WP-1:0]    iw_en;
  logic [WP*AW-1:0] iw_a;
  logic [WP*DW-1:0] iw_av;
  logic             rsv_en;
  logic [AW-1:0]    rsv_a;

  int applied = 0;
  int miscompares = 0;
  vec_t vt[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  register_mp #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .READ_PORTS(RP),
    .WRITE_PORTS(WP),
    .ZERO_REG(1)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .STALL(stall),
    .REG_IR_I_A(ir_a),
    .REG_IR_O_A(or_a),
    .REG_IR_O_AV(or_av),
    .REG_IR_O_BUSY(or_busy),
    .REG_IW_I_EN(iw_en),
    .REG_IW_I_A(iw_a),
    .REG_IW_I_AV(iw_av),
    .REG_RSV_I_EN(rsv_en),
    .REG_RSV_I_A(rsv_a)
  );

  function automatic vec_t mk(
    input logic r, input logic s,
    input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
    input logic [1:0] wen,
    input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
    input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
    input logic rsv, input logic [AW-1:0] rsva,
    input logic chk,
    input logic [AW-1:0] oa0, input logic [AW-1:0] oa1,
    input logic [DW-1:0] av0, input logic [DW-1:0] av1,
    input logic [1:0] bz);
    vec_t v;
    v.rst = r;    v.stall = s;
    v.ra0 = ra0;  v.ra1 = ra1;
    v.wen = wen;
    v.wa0 = wa0;  v.wd0 = wd0;
    v.wa1 = wa1;  v.wd1 = wd1;
    v.rsv = rsv;  v.rsva = rsva;
    v.chk = chk;
    v.oa0 = oa0;  v.oa1 = oa1;
    v.av0 = av0;  v.av1 = av1;
    v.bz = bz;
    return v;
  endfunction

  task automatic cmp(input string n, input logic [DW-1:0] got,
                     input logic [DW-1:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h expected %h",
               n, applied, got, want);
    end
  endtask

  // Drive one cycle of stimulus; expected outputs for this cycle go
  // through the scoreboard and are compared once the outputs settle.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst    = v.rst;
    stall  = v.stall;
    ir_a   = {v.ra1, v.ra0};
    iw_en  = v.wen;
    iw_a   = {v.wa1, v.wa0};
    iw_av  = {v.wd1, v.wd0};
    rsv_en = v.rsv;
    rsv_a  = v.rsva;
    if (v.chk) begin
      e.oa0 = v.oa0; e.oa1 = v.oa1;
      e.av0 = v.av0; e.av1 = v.av1;
      e.bz  = v.bz;
      sb.push_back(e);
    end
    #1;
    if (v.chk) begin
      e = sb.pop_front();
      cmp("oa0", {27'd0, or_a[AW-1:0]}, {27'd0, e.oa0});
      cmp("oa1", {27'd0, or_a[2*AW-1:AW]}, {27'd0, e.oa1});
      cmp("av0", or_av[DW-1:0], e.av0);
      cmp("av1", or_av[2*DW-1:DW], e.av1);
      cmp("busy", {30'd0, or_busy}, {30'd0, e.bz});
      applied++;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; ir_a = '0; iw_en = '0;
    iw_a = '0; iw_av = '0; rsv_en = 1'b0; rsv_a = '0;

    // reset, idle reads, x0 write dropped
    vt.push_back(mk(1,0, 1,2, 2'b00,0,0,0,0, 0,0, 0, 0,0,0,0,2'b00));
    vt.push_back(mk(0,0, 1,2, 2'b00,0,0,0,0, 0,0, 1, 0,0,0,0,2'b00));
    vt.push_back(mk(0,0, 0,0, 2'b01,0,32'hDEADBEEF,0,0, 0,0, 1, 1,2,0,0,2'b00));
    // basic write/read of r5
    vt.push_back(mk(0,0, 0,5, 2'b01,5,32'h12345678,0,0, 0,0, 1, 0,0,0,0,2'b00));
    vt.push_back(mk(0,0, 5,7, 2'b00,0,0,0,0, 0,0, 1, 0,5,0,32'h12345678,2'b00));
    // forwarding r7, then from array
    vt.push_back(mk(0,0, 7,5, 2'b01,7,32'hA5A5A5A5,0,0, 0,0, 1, 5,7,32'h12345678,32'hA5A5A5A5,2'b00));
    // collision on r3
    vt.push_back(mk(0,0, 3,3, 2'b11,3,1,3,2, 0,0, 1, 7,5,32'hA5A5A5A5,32'h12345678,2'b00));
    // reserve r9
    vt.push_back(mk(0,0, 3,9, 2'b00,0,0,0,0, 1,9, 1, 3,3,2,2,2'b00));
    vt.push_back(mk(0,0, 9,9, 2'b00,0,0,0,0, 0,0, 1, 3,9,2,0,2'b10));
    vt.push_back(mk(0,0, 9,9, 2'b01,9,32'hCAFEF00D,0,0, 0,0, 1, 9,9,32'hCAFEF00D,32'hCAFEF00D,2'b00));
    // reserve and write r9 on the same edge
    vt.push_back(mk(0,0, 9,9, 2'b01,9,32'h11111111,0,0, 1,9, 1, 9,9,32'h11111111,32'h11111111,2'b00));
    vt.push_back(mk(0,0, 9,9, 2'b00,0,0,0,0, 0,0, 1, 9,9,32'h11111111,32'h11111111,2'b11));
    // three-cycle stall: addresses held, reserve ignored, writes land
    vt.push_back(mk(0,1, 1,2, 2'b01,6,32'h66666666,0,0, 1,4, 1, 9,9,32'h11111111,32'h11111111,2'b11));
    vt.push_back(mk(0,1, 4,6, 2'b10,0,0,9,32'h99999999, 0,0, 1, 9,9,32'h99999999,32'h99999999,2'b00));
    vt.push_back(mk(0,1, 5,5, 2'b00,0,0,0,0, 0,0, 1, 9,9,32'h99999999,32'h99999999,2'b00));
    vt.push_back(mk(0,0, 4,4, 2'b00,0,0,0,0, 1,0, 1, 9,9,32'h99999999,32'h99999999,2'b00));
    vt.push_back(mk(0,0, 6,0, 2'b00,0,0,0,0, 0,0, 1, 4,4,0,0,2'b00));
    vt.push_back(mk(0,0, 0,0, 2'b00,0,0,0,0, 1,9, 1, 6,0,32'h66666666,0,2'b00));
    // reset during stall, write and reserve
    vt.push_back(mk(1,1, 4,9, 2'b01,4,32'h77777777,0,0, 1,4, 1, 0,0,0,0,2'b00));
    vt.push_back(mk(0,0, 4,9, 2'b00,0,0,0,0, 0,0, 1, 0,0,0,0,2'b00));
    vt.push_back(mk(0,0, 0,0, 2'b00,0,0,0,0, 0,0, 1, 4,9,0,0,2'b00));

    for (int i = 0; i < vt.size(); i++)
      step(vt[i]);

    // busy held over several cycles until the producer writes back
    step(mk(0,0, 10,10, 2'b00,0,0,0,0, 1,10, 1, 0,0,0,0,2'b00));
    step(mk(0,0, 10,10, 2'b00,0,0,0,0, 0,0, 1, 10,10,0,0,2'b11));
    step(mk(0,0, 10,10, 2'b00,0,0,0,0, 0,0, 1, 10,10,0,0,2'b11));
    step(mk(0,0, 10,10, 2'b10,0,0,10,32'hABCD0123, 0,0, 1, 10,10,32'hABCD0123,32'hABCD0123,2'b00));
    step(mk(0,0, 10,10, 2'b00,0,0,0,0, 0,0, 1, 10,10,32'hABCD0123,32'hABCD0123,2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
